// File: rtl/cosmac_pkg.sv
// Shared types and constants for the COSMAC memory responder.
package cosmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HIADR,
        BUS,
        RD,
        WR
    } state_e;

    localparam int SYNC_STAGES = 2;

    localparam logic XCLK_RST  = 1'b0;
    localparam logic CLR_RST   = 1'b0;
    localparam logic NWAIT_RST = 1'b1;

endpackage

// File: rtl/cosmac_ram.sv
// Single-port byte RAM, synchronous read with one clock of latency.
module cosmac_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           rdata_o
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/cosmac_mem_responder.sv
// CDP1802 bus responder: CPU clock/CLEAR generation, address demux,
// RAM reads onto the data bus and TPB-committed writes.
module cosmac_mem_responder
    import cosmac_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int CLK_DIV    = 4,
    parameter int CLR_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       xclk,
    output logic       nwait,
    output logic       clr,
    input  logic       nmwr,
    input  logic       nmrd,
    input  logic       tpa,
    input  logic       tpb,
    input  logic [7:0] ma,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    output logic       bus_err
);

    localparam int SW  = 20;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CCW = $clog2(CLR_CYCLES) + 1;
    // Strobes idle high so reset never looks like a bus request.
    localparam logic [SW-1:0] SYNC_RST = {2'b11, 18'h0};

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic       nmwr_s, nmrd_s, tpa_s, tpb_s;
    logic [7:0] ma_s, db_in_s;

    logic [DW-1:0]  div_q;
    logic [CCW-1:0] clr_cnt_q;
    logic           xclk_q, clr_q, div_wrap, xclk_rise;

    logic           tpa_prev_q, tpb_prev_q, tpa_rise, tpa_fall, tpb_rise;
    state_e         state_q, state_d;
    logic [7:0]     addr_hi_q, addr_hi_d;
    logic [7:0]     db_out_q, db_out_d;
    logic           db_oe_q, db_oe_d, bus_err_q, bus_err_d;
    logic           ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [7:0]     ram_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= {SYNC_STAGES{SYNC_RST}};
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], {nmwr, nmrd, tpa, tpb, ma, db_in}};
    end

    assign {nmwr_s, nmrd_s, tpa_s, tpb_s, ma_s, db_in_s} = sync_q[SYNC_STAGES-1];

    assign div_wrap  = (div_q == DW'(CLK_DIV - 1));
    assign xclk_rise = div_wrap && !xclk_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            xclk_q    <= XCLK_RST;
            clr_cnt_q <= '0;
            clr_q     <= CLR_RST;
        end else begin
            div_q <= div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) xclk_q <= ~xclk_q;
            if (!clr_q && xclk_rise) begin
                if (clr_cnt_q == CCW'(CLR_CYCLES - 1)) clr_q <= 1'b1;
                else                                   clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    assign tpa_rise = tpa_s && !tpa_prev_q;
    assign tpa_fall = !tpa_s && tpa_prev_q;
    assign tpb_rise = tpb_s && !tpb_prev_q;

    // The RAM address follows ma every cycle so the read is already in
    // flight in the cycle that decides to enter RD.
    assign ram_addr = ADDR_BITS'({addr_hi_q, ma_s});

    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        ram_we    = 1'b0;
        case (state_q)
            IDLE:  if (tpa_rise) state_d = HIADR;
            HIADR: if (tpa_fall) begin
                       addr_hi_d = ma_s;
                       state_d   = BUS;
                   end
            BUS:   if (!nmrd_s)       state_d = RD;
                   else if (!nmwr_s)  state_d = WR;
                   else if (tpa_rise) state_d = HIADR;
            RD:    if (tpa_rise)      state_d = HIADR;
                   else if (nmrd_s)   state_d = IDLE;
            WR:    if (nmwr_s)        state_d = IDLE;
                   else if (!nmrd_s)  state_d = RD;
                   else if (tpb_rise) begin
                       ram_we  = 1'b1;
                       state_d = IDLE;
                   end
            default: state_d = IDLE;
        endcase
        db_oe_d   = (state_q == RD) && (state_d == RD);
        db_out_d  = (state_q == RD) ? ram_rdata : db_out_q;
        bus_err_d = bus_err_q || (!nmrd_s && !nmwr_s);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_hi_q  <= '0;
            tpa_prev_q <= 1'b0;
            tpb_prev_q <= 1'b0;
            db_out_q   <= '0;
            db_oe_q    <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_hi_q  <= addr_hi_d;
            tpa_prev_q <= tpa_s;
            tpb_prev_q <= tpb_s;
            db_out_q   <= db_out_d;
            db_oe_q    <= db_oe_d;
            bus_err_q  <= bus_err_d;
        end
    end

    cosmac_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (db_in_s),
        .rdata_o (ram_rdata)
    );

    assign xclk    = xclk_q;
    assign clr     = clr_q;
    assign nwait   = NWAIT_RST;
    assign db_out  = db_out_q;
    // The pads never drive while the CPU is also asserting a write.
    assign db_oe   = db_oe_q && nmwr_s;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_cosmac_mem_responder.sv
// Scoreboard bench: stimulus pushes expected read bytes, a monitor checks
// db_out on every rising db_oe; direct checks cover timing and side effects.
module tb_cosmac_mem_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       xclk, nwait, clr, db_oe, bus_err;
    logic       nmwr = 1'b1, nmrd = 1'b1, tpa = 1'b0, tpb = 1'b0;
    logic [7:0] ma = 8'h00, db_in = 8'h00, db_out;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [7:0] exp_q [$];
    logic oe_prev = 1'b0;

    cosmac_mem_responder #(.ADDR_BITS(10), .CLK_DIV(4), .CLR_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn), .xclk(xclk), .nwait(nwait), .clr(clr),
        .nmwr(nmwr), .nmrd(nmrd), .tpa(tpa), .tpb(tpb), .ma(ma),
        .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: score the byte presented on each new db_oe assertion, count writes.
    always @(negedge clk) begin
        logic [7:0] e;
        if (resetn && db_oe && !oe_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_oe: got db_out %0h with no read expected", db_out);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(db_out), 32'(e));
            end
        end
        oe_prev = db_oe;
        if (dut.ram_we === 1'b1) wr_cnt++;
    end

    task automatic addr_phase(input logic [7:0] hi, input logic [7:0] lo);
        tpa = 1'b1; ma = hi; tick(4);
        tpa = 1'b0; tick(1);
        ma = lo; tick(3);
    endtask

    task automatic do_read(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] exp, input bit timed);
        addr_phase(hi, lo);
        exp_q.push_back(exp);
        nmrd = 1'b0;
        if (timed) begin
            tick(3); chk("oe_lat3", 32'(db_oe), 0);
            tick(1); chk("oe_lat4", 32'(db_oe), 1);
            tick(2); nmrd = 1'b1;
            tick(2); chk("oe_hold", 32'(db_oe), 1);
            tick(1); chk("oe_off", 32'(db_oe), 0);
            tick(2);
        end else begin
            tick(6); nmrd = 1'b1; tick(4);
        end
    endtask

    task automatic do_write(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] d);
        int w0;
        addr_phase(hi, lo);
        w0 = wr_cnt;
        db_in = d; nmwr = 1'b0; tick(4);
        tpb = 1'b1; tick(4);
        tpb = 1'b0; tick(2);
        nmwr = 1'b1; tick(4);
        chk("wr_count", 32'(wr_cnt - w0), 1);
        chk("wr_mem", 32'(dut.u_ram.mem[10'({hi, lo})]), 32'(d));
    endtask

    initial begin
        int rises, w0;
        bit prev_x, done;

        dut.u_ram.mem[5] = 8'hA5;
        tick(2);
        chk("rst_xclk", 32'(xclk), 0);
        chk("rst_clr", 32'(clr), 0);
        chk("rst_nwait", 32'(nwait), 1);
        chk("rst_db_oe", 32'(db_oe), 0);
        chk("rst_db_out", 32'(db_out), 0);
        chk("rst_bus_err", 32'(bus_err), 0);

        resetn = 1'b1;
        tick(3); chk("xclk_pre", 32'(xclk), 0);
        tick(1); chk("xclk_first", 32'(xclk), 1);
        rises = 1; prev_x = 1'b1; done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            tick(1);
            if (xclk && !prev_x) begin
                rises++;
                if (rises == 15) chk("clr_at15", 32'(clr), 0);
                if (rises == 16) begin
                    chk("clr_at16", 32'(clr), 1);
                    done = 1'b1;
                end
            end
            prev_x = xclk;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL clr_timeout: got %0d xclk rises, required 16", rises);
        end

        do_read(8'h00, 8'h05, 8'hA5, 1'b1);

        do_write(8'h00, 8'h07, 8'h3C);
        do_read(8'h00, 8'h07, 8'h3C, 1'b1);
        do_write(8'h01, 8'h20, 8'hC3);

        // Back-to-back reads: nmrd stays low across the TPA of the next cycle.
        for (int i = 0; i < 8; i++) dut.u_ram.mem[i] = 8'(i);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(i));
            addr_phase(8'h00, 8'(i));
            nmrd = 1'b0;
            tick(6);
        end
        nmrd = 1'b1; tick(4);

        // Read and write strobes together: read wins, no write, error latched.
        dut.u_ram.mem[9] = 8'h5A;
        addr_phase(8'h00, 8'h09);
        w0 = wr_cnt;
        db_in = 8'hFF; nmrd = 1'b0; nmwr = 1'b0; tick(4);
        tpb = 1'b1; tick(4);
        tpb = 1'b0; tick(2);
        chk("err_flag", 32'(bus_err), 1);
        chk("err_db_out", 32'(db_out), 32'h5A);
        chk("err_oe_gated", 32'(db_oe), 0);
        chk("err_mem", 32'(dut.u_ram.mem[9]), 32'h5A);
        chk("err_no_write", 32'(wr_cnt - w0), 0);
        exp_q.push_back(8'h5A);
        nmwr = 1'b1; tick(4);
        nmrd = 1'b1; tick(4);

        // Reset in the middle of a read, away from any clock edge.
        addr_phase(8'h00, 8'h09);
        exp_q.push_back(8'h5A);
        nmrd = 1'b0; tick(6);
        chk("mid_oe_on", 32'(db_oe), 1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_oe_off", 32'(db_oe), 0);
        chk("mid_db_out", 32'(db_out), 0);
        chk("mid_bus_err", 32'(bus_err), 0);
        chk("mid_clr", 32'(clr), 0);
        nmrd = 1'b1;
        tick(1);
        resetn = 1'b1;
        tick(2);
        chk("mid_state", 32'(dut.state_q), 32'(cosmac_pkg::IDLE));

        // {05,20} aliases to 0x120 with a 10-bit RAM.
        do_read(8'h05, 8'h20, 8'hC3, 1'b1);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

endmodule
